pipelined_accum: RTL and testbench
==================================

Name: pipelined_accum

Overview:
- Pipelined signed adder tree followed by a running accumulator.
- Each cycle it reduces 2^LOG2_NO_IN signed input words to one sum and folds that sum into an accumulator; a new_sum strobe restarts the accumulation.
- Sits behind the multiply stage of the fixed-point multiply-accumulate datapath, which feeds it products and aligns new_sum with them.

Parameters:
- IN_BITWIDTH, 16, width of each signed input word.
- OUT_BITWIDTH, 16, width of tree nodes, accumulator and data_out. Must be >= IN_BITWIDTH.
- LOG2_NO_IN, 1, log2 of the number of input words. 0 is legal and means a single input with no tree.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- new_sum  input  1  restart strobe, aligned with data_in. When high, this cycle's input sum starts a new accumulation instead of adding to the previous one.
- data_in  input  (2^LOG2_NO_IN) x IN_BITWIDTH  packed array of signed two's-complement words. Element i is data_in[i].
- data_out  output  OUT_BITWIDTH  signed accumulator value, driven directly from a register.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n). All registers clear to 0 when rst_n=0, including every tree stage, the new_sum delay pipe and the accumulator, so data_out=0 during reset.
- Inputs are sign-extended from IN_BITWIDTH to OUT_BITWIDTH.
- Adder tree:
  - LOG2_NO_IN levels, each level registered.
  - Level k node j = node(k-1, 2j) + node(k-1, 2j+1), computed at OUT_BITWIDTH.
  - Overflow wraps modulo 2^OUT_BITWIDTH; no saturation.
  - Tree result is valid LOG2_NO_IN cycles after data_in is sampled.
  - For LOG2_NO_IN=0 the tree is a wire carrying the sign-extended data_in[0].
- new_sum is delayed through a LOG2_NO_IN-deep register pipe so that it arrives at the accumulator with its own data.
- Accumulator, every rising clk edge (no enable; it accumulates every cycle):
  - If delayed new_sum=1: acc <= tree_sum.
  - Otherwise: acc <= acc + tree_sum, wrapping modulo 2^OUT_BITWIDTH.
- data_out = acc.
- Latency: a data_in/new_sum pair sampled at edge t affects data_out immediately after edge t+LOG2_NO_IN. Total latency is LOG2_NO_IN+1 edges from sampling to visible output.
- Throughput: one input vector per cycle, fully pipelined, no stalls.
- new_sum held high for consecutive cycles: each cycle reloads, so data_out shows each individual tree sum in turn.
- new_sum never asserted after reset: the accumulator starts from 0 and keeps summing.
- Reset mid-accumulation clears all state asynchronously. Data already in the pipe is discarded. After release, accumulation restarts from 0 without needing a new_sum.
- Simultaneous new_sum and nonzero data: the new sum includes that data. The reload takes precedence over the add, and the old acc is discarded.

Test Plan:
- Reset: drive rst_n=0 mid-run with nonzero pipe contents -> data_out=0 immediately, without waiting for a clk edge. After release with data_in all 0, data_out stays 0.
- Basic sum, LOG2_NO_IN=1, IN=OUT=16:
  - Cycle 0: data_in={3,5}, new_sum=1. Then data_in={1,1}, new_sum=0 for 3 cycles.
  - data_out sequence from edge 1 onward: 8, 10, 12, 14.
- Restart: after the above, data_in={-2,-4} (0xFFFE, 0xFFFC) with new_sum=1 -> two edges later data_out=0xFFFA (-6). The following cycle with {1,1} and new_sum=0 gives 0xFFFC.
- Latency/alignment, LOG2_NO_IN=2:
  - Inputs: a single vector {1,2,3,4} with new_sum=1, followed by zeros with new_sum=0.
  - Required response: data_out becomes 10 exactly 3 edges after sampling and stays at 10.
- Wrap, LOG2_NO_IN=1, IN=OUT=8:
  - Inputs: {127,1} with new_sum=1, then {0,0}.
  - Required response: data_out = 0x80 (-128), then holds at 0x80.
- Sign extension, IN=8, OUT=16, LOG2_NO_IN=0:
  - Inputs: data_in=0xFF with new_sum=1, then 0xFF held.
  - Required response: data_out = 0xFFFF, then 0xFFFE, then 0xFFFD.

Source files
------------

// File: rtl/pipelined_accum_if.sv
// pipelined_accum_if
// Bundles the data-path signals of the pipelined adder-tree accumulator.
// The producer (multiply stage or bench) uses the master modport and the
// accumulator uses the slave modport.
//   new_sum  : restart strobe, aligned with data_in
//   data_in  : NO_IN packed signed words of IN_BITWIDTH bits, element i = data_in[i]
//   data_out : signed accumulator value, OUT_BITWIDTH bits
interface pipelined_accum_if #(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 16,
    parameter int LOG2_NO_IN   = 1
);
    localparam int NO_IN = 1 << LOG2_NO_IN;

    logic                                 new_sum;
    logic [NO_IN-1:0][IN_BITWIDTH-1:0]    data_in;
    logic [OUT_BITWIDTH-1:0]              data_out;

    modport master (
        output new_sum,
        output data_in,
        input  data_out
    );

    modport slave (
        input  new_sum,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/pipelined_accum.sv
// pipelined_accum
// Pipelined signed adder tree followed by a running accumulator. Every cycle
// the 2^LOG2_NO_IN input words are sign-extended, reduced through LOG2_NO_IN
// registered adder levels and folded into the accumulator. A new_sum strobe,
// delayed to stay aligned with its data, reloads the accumulator instead of
// adding to it. All arithmetic wraps modulo 2^OUT_BITWIDTH.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every register
//   bus   : pipelined_accum_if slave (new_sum, data_in in; data_out out)
module pipelined_accum #(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 16,
    parameter int LOG2_NO_IN   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_accum_if.slave   bus
);
    localparam int NO_IN = 1 << LOG2_NO_IN;

    logic signed [OUT_BITWIDTH-1:0] ext [NO_IN];
    logic signed [OUT_BITWIDTH-1:0] tree_sum;
    logic                           new_sum_d;
    logic signed [OUT_BITWIDTH-1:0] acc;

    // Sign-extend every input word to the tree width.
    for (genvar i = 0; i < NO_IN; i++) begin : g_ext
        assign ext[i] = OUT_BITWIDTH'($signed(bus.data_in[i]));
    end

    if (LOG2_NO_IN == 0) begin : g_bypass
        assign tree_sum  = ext[0];
        assign new_sum_d = bus.new_sum;
    end else begin : g_tree
        // Internal nodes are stored heap-style: node n has children 2n+1 and
        // 2n+2, the root is node 0, and indices NO_IN-1 and up are the leaves
        // (the sign-extended inputs). Every node at one depth belongs to the
        // same pipeline level, so the tree adds one register per level.
        logic signed [OUT_BITWIDTH-1:0] node_d [NO_IN-1];
        logic signed [OUT_BITWIDTH-1:0] node_q [NO_IN-1];
        logic [LOG2_NO_IN-1:0]          ns_pipe;

        for (genvar n = 0; n < NO_IN - 1; n++) begin : g_node
            localparam int LEFT  = 2 * n + 1;
            localparam int RIGHT = 2 * n + 2;
            logic signed [OUT_BITWIDTH-1:0] lhs;
            logic signed [OUT_BITWIDTH-1:0] rhs;

            if (LEFT >= NO_IN - 1) begin : g_leaf
                assign lhs = ext[LEFT - (NO_IN - 1)];
                assign rhs = ext[RIGHT - (NO_IN - 1)];
            end else begin : g_inner
                assign lhs = node_q[LEFT];
                assign rhs = node_q[RIGHT];
            end

            assign node_d[n] = lhs + rhs;
        end

        // Tree registers and the matching new_sum delay line advance together
        // so the strobe reaches the accumulator in the same cycle as its sum.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int n = 0; n < NO_IN - 1; n++) begin
                    node_q[n] <= '0;
                end
                ns_pipe <= '0;
            end else begin
                node_q     <= node_d;
                ns_pipe[0] <= bus.new_sum;
                for (int i = 1; i < LOG2_NO_IN; i++) begin
                    ns_pipe[i] <= ns_pipe[i-1];
                end
            end
        end

        assign tree_sum  = node_q[0];
        assign new_sum_d = ns_pipe[LOG2_NO_IN-1];
    end

    // Accumulates every cycle; a delayed new_sum discards the old total and
    // reloads with the current tree sum, which includes that cycle's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (new_sum_d) begin
            acc <= tree_sum;
        end else begin
            acc <= acc + tree_sum;
        end
    end

    assign bus.data_out = acc;
endmodule

// File: tb/tb_pipelined_accum.sv
// tb_pipelined_accum
// Directed bench for pipelined_accum. Four instances cover the configurations
// of interest: A (16/16, 2 inputs), B (16/16, 4 inputs), C (8/8, 2 inputs)
// and D (8 in / 16 out, single input, no tree). A runs from a vector table;
// reset, latency, wrap and sign extension use hand-written sequences.
module tb_pipelined_accum;

    logic clk = 1'b0;
    logic rst_n;
    int   checks_done   = 0;
    int   checks_failed = 0;

    always #5 clk = ~clk;

    pipelined_accum_if #(.IN_BITWIDTH(16), .OUT_BITWIDTH(16), .LOG2_NO_IN(1)) bus_a ();
    pipelined_accum_if #(.IN_BITWIDTH(16), .OUT_BITWIDTH(16), .LOG2_NO_IN(2)) bus_b ();
    pipelined_accum_if #(.IN_BITWIDTH(8),  .OUT_BITWIDTH(8),  .LOG2_NO_IN(1)) bus_c ();
    pipelined_accum_if #(.IN_BITWIDTH(8),  .OUT_BITWIDTH(16), .LOG2_NO_IN(0)) bus_d ();

    pipelined_accum #(.IN_BITWIDTH(16), .OUT_BITWIDTH(16), .LOG2_NO_IN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    pipelined_accum #(.IN_BITWIDTH(16), .OUT_BITWIDTH(16), .LOG2_NO_IN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));
    pipelined_accum #(.IN_BITWIDTH(8),  .OUT_BITWIDTH(8),  .LOG2_NO_IN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c));
    pipelined_accum #(.IN_BITWIDTH(8),  .OUT_BITWIDTH(16), .LOG2_NO_IN(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .bus(bus_d));

    // One table row: inputs for instance A sampled at an edge, and the value
    // data_out must show just after that same edge (reflecting older inputs).
    typedef struct {
        logic        new_sum;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [12];

    task automatic applyStimulus(input logic ns, input logic [15:0] d0, input logic [15:0] d1);
        bus_a.new_sum    = ns;
        bus_a.data_in[0] = d0;
        bus_a.data_in[1] = d1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic zeroAll();
        applyStimulus(1'b0, 16'd0, 16'd0);
        bus_b.new_sum = 1'b0;
        bus_b.data_in = '0;
        bus_c.new_sum = 1'b0;
        bus_c.data_in = '0;
        bus_d.new_sum = 1'b0;
        bus_d.data_in = '0;
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        zeroAll();

        // Basic sum, restart and back-to-back reloads on instance A.
        vecs[0]  = '{1'b1, 16'd3,    16'd5,    16'h0000};
        vecs[1]  = '{1'b0, 16'd1,    16'd1,    16'd8};
        vecs[2]  = '{1'b0, 16'd1,    16'd1,    16'd10};
        vecs[3]  = '{1'b0, 16'd1,    16'd1,    16'd12};
        vecs[4]  = '{1'b1, 16'hFFFE, 16'hFFFC, 16'd14};
        vecs[5]  = '{1'b0, 16'd1,    16'd1,    16'hFFFA};
        vecs[6]  = '{1'b0, 16'd0,    16'd0,    16'hFFFC};
        vecs[7]  = '{1'b0, 16'd0,    16'd0,    16'hFFFC};
        vecs[8]  = '{1'b1, 16'd7,    16'd0,    16'hFFFC};
        vecs[9]  = '{1'b1, 16'd5,    16'd5,    16'd7};
        vecs[10] = '{1'b0, 16'd0,    16'd0,    16'd10};
        vecs[11] = '{1'b0, 16'd0,    16'd0,    16'd10};

        #12;
        checkOutput("reset_a", bus_a.data_out, 16'h0000);
        checkOutput("reset_b", bus_b.data_out, 16'h0000);
        checkOutput("reset_c", {8'h00, bus_c.data_out}, 16'h0000);
        checkOutput("reset_d", bus_d.data_out, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            afterEdge();
            checkOutput($sformatf("idle_a_%0d", i), bus_a.data_out, 16'h0000);
        end

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].new_sum, vecs[i].d0, vecs[i].d1);
            afterEdge();
            checkOutput($sformatf("vec_%0d", i), bus_a.data_out, vecs[i].exp_out);
        end

        // Mid-run asynchronous reset with nonzero data sitting in the tree.
        @(negedge clk);
        applyStimulus(1'b0, 16'd9, 16'd9);
        afterEdge();
        checkOutput("pre_reset_a", bus_a.data_out, 16'd10);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_a", bus_a.data_out, 16'h0000);
        @(negedge clk);
        zeroAll();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            afterEdge();
            checkOutput($sformatf("post_reset_a_%0d", i), bus_a.data_out, 16'h0000);
        end

        // Latency (B), wrap (C) and sign extension (D) run side by side.
        @(negedge clk);
        bus_b.new_sum    = 1'b1;
        bus_b.data_in[0] = 16'd1;
        bus_b.data_in[1] = 16'd2;
        bus_b.data_in[2] = 16'd3;
        bus_b.data_in[3] = 16'd4;
        bus_c.new_sum    = 1'b1;
        bus_c.data_in[0] = 8'h7F;
        bus_c.data_in[1] = 8'h01;
        bus_d.new_sum    = 1'b1;
        bus_d.data_in[0] = 8'hFF;
        afterEdge();
        checkOutput("lat_b_e0", bus_b.data_out, 16'd0);
        checkOutput("wrap_c_e0", {8'h00, bus_c.data_out}, 16'h0000);
        checkOutput("sext_d_e0", bus_d.data_out, 16'hFFFF);

        @(negedge clk);
        bus_b.new_sum = 1'b0;
        bus_b.data_in = '0;
        bus_c.new_sum = 1'b0;
        bus_c.data_in = '0;
        bus_d.new_sum = 1'b0;
        afterEdge();
        checkOutput("lat_b_e1", bus_b.data_out, 16'd0);
        checkOutput("wrap_c_e1", {8'h00, bus_c.data_out}, 16'h0080);
        checkOutput("sext_d_e1", bus_d.data_out, 16'hFFFE);

        afterEdge();
        checkOutput("lat_b_e2", bus_b.data_out, 16'd10);
        checkOutput("wrap_c_e2", {8'h00, bus_c.data_out}, 16'h0080);
        checkOutput("sext_d_e2", bus_d.data_out, 16'hFFFD);

        @(negedge clk);
        bus_d.data_in = '0;
        afterEdge();
        checkOutput("lat_b_e3", bus_b.data_out, 16'd10);
        checkOutput("wrap_c_e3", {8'h00, bus_c.data_out}, 16'h0080);
        checkOutput("sext_d_e3", bus_d.data_out, 16'hFFFD);

        afterEdge();
        checkOutput("lat_b_e4", bus_b.data_out, 16'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
